// File: rtl/parity_frame_rx.sv
// UART-style serial frame receiver (start, DATA_W data bits LSB-first, odd parity, stop)
// with a one-word valid/ready output buffer. Define PARITY_RX_STATS_EN to add the err_cnt port.
module parity_frame_rx #(
  parameter int DATA_W   = 3,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr,
  output logic              busy
`ifdef PARITY_RX_STATS_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int HALF  = BAUD_DIV / 2;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;

  logic complete;
  logic word_par_err;
  logic word_frm_err;

  // The stop bit is sampled on this edge; the word and its flags are final here.
  assign complete     = (state == STOP) && (cnt == BIT_LAST);
  assign word_par_err = ~(^{shreg, par_bit});
  assign word_frm_err = ~rx_in;
  assign busy         = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of cnt/idx/state, exactly like the hardware does.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_in) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            if (rx_in) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_in;
            if (idx == IDX_LAST) state <= PARITY;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_in;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rx_in ? IDLE : WAIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          // A low line here is a stuck/broken stop, not a new start bit.
          if (rx_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer: the receiver never waits, so a word arriving while the
  // buffer is full and not being drained is dropped and flagged by ovr.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_data  <= shreg;
          par_err   <= word_par_err;
          frm_err   <= word_frm_err;
          out_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_RX_STATS_EN
  // Counts every errored frame, delivered or dropped; sticks at 255.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      err_cnt <= '0;
    end else if (complete && (word_par_err || word_frm_err) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed self-checking bench for parity_frame_rx at DATA_W=3, BAUD_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_in;
  logic [2:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       par_err;
  logic       frm_err;
  logic       ovr;
  logic       busy;
`ifdef PARITY_RX_STATS_EN
  logic [7:0] err_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(3), .BAUD_DIV(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_in     (rx_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .ovr       (ovr),
    .busy      (busy)
`ifdef PARITY_RX_STATS_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Drives start, data, parity and the stop level; returns on the falling edge
  // right after T0+21, so one more step() lands just after the stop-sample edge.
  task automatic drive_until(input logic [2:0] d, input logic p, input logic stop);
    send(1'b0, 4);
    for (int i = 0; i < 3; i++) send(d[i], 4);
    send(p, 4);
    rx_in = stop;
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_valid;
    logic seen_ovr;

    n_rst     = 1'b0;
    rx_in     = 1'b1;
    out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data,  0);
    check("rst_par",   par_err,   0);
    check("rst_frm",   frm_err,   0);
    check("rst_ovr",   ovr,       0);
    check("rst_busy",  busy,      0);
`ifdef PARITY_RX_STATS_EN
    check("rst_errcnt", err_cnt, 0);
`endif
    n_rst = 1'b1;
    repeat (2) step();

    // 1: good frame 3'b101, p=1, exact latency T0+22
    out_ready = 1'b1;
    drive_until(3'b101, 1'b1, 1'b1);
    check("t1_valid_early", out_valid, 0);
    check("t1_busy_early",  busy,      1);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_data",  out_data,  3'b101);
    check("t1_par",   par_err,   0);
    check("t1_frm",   frm_err,   0);
    check("t1_busy",  busy,      0);
    step();
    check("t1_accepted", out_valid, 0);
    check("t1_data_hold", out_data, 3'b101);

    // 2: data 3'b011 with p=0 gives an even ones count -> parity error, still delivered
    drive_until(3'b011, 1'b0, 1'b1);
    step();
    check("t2_valid", out_valid, 1);
    check("t2_data",  out_data,  3'b011);
    check("t2_par",   par_err,   1);
    check("t2_frm",   frm_err,   0);
`ifdef PARITY_RX_STATS_EN
    check("t2_errcnt", err_cnt, 1);
`endif
    step();

    // 3: stop bit 0, line held low 10 cycles from the stop bit start
    drive_until(3'b010, 1'b0, 1'b0);
    step();
    check("t3_valid", out_valid, 1);
    check("t3_data",  out_data,  3'b010);
    check("t3_par",   par_err,   0);
    check("t3_frm",   frm_err,   1);
    check("t3_busy",  busy,      1);
`ifdef PARITY_RX_STATS_EN
    check("t3_errcnt", err_cnt, 2);
`endif
    repeat (7) step();
    check("t3_busy_low_line", busy,      1);
    check("t3_no_new_word",   out_valid, 0);
    rx_in = 1'b1;
    step();
    check("t3_idle_after_high", busy, 0);
    repeat (3) step();
    check("t3_still_idle", busy, 0);

    // 4: one-cycle glitch low -> START aborts, nothing reported
    rx_in = 1'b0;
    step();
    check("t4_start", busy, 1);
    rx_in = 1'b1;
    repeat (2) step();
    check("t4_abort", busy, 0);
    seen_valid = 1'b0;
    seen_ovr   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      seen_valid |= out_valid;
      seen_ovr   |= ovr;
    end
    check("t4_no_valid", seen_valid, 0);
    check("t4_no_ovr",   seen_ovr,   0);
`ifdef PARITY_RX_STATS_EN
    check("t4_errcnt", err_cnt, 2);
`endif

    // 5: out_ready=0, back-to-back 3'b001 then 3'b110 -> second dropped
    out_ready = 1'b0;
    drive_until(3'b001, 1'b0, 1'b1);
    step();
    check("t5_first_valid", out_valid, 1);
    check("t5_first_data",  out_data,  3'b001);
    check("t5_first_ovr",   ovr,       0);
    send(1'b1, 1);
    drive_until(3'b110, 1'b1, 1'b1);
    check("t5_ovr_before", ovr, 0);
    step();
    check("t5_ovr_pulse", ovr,       1);
    check("t5_data_kept", out_data,  3'b001);
    check("t5_valid_kept", out_valid, 1);
    step();
    check("t5_ovr_clear", ovr,      0);
    check("t5_data_still", out_data, 3'b001);

    // 6: reset mid-DATA with a word held, then a clean frame 3'b111, p=0
    send(1'b0, 8);
    check("t6_busy_mid", busy, 1);
    n_rst = 1'b0;
    step();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data",  out_data,  0);
    check("t6_rst_par",   par_err,   0);
    check("t6_rst_frm",   frm_err,   0);
    check("t6_rst_ovr",   ovr,       0);
    check("t6_rst_busy",  busy,      0);
`ifdef PARITY_RX_STATS_EN
    check("t6_rst_errcnt", err_cnt, 0);
`endif
    n_rst = 1'b1;
    rx_in = 1'b1;
    repeat (2) step();
    out_ready = 1'b1;
    drive_until(3'b111, 1'b0, 1'b1);
    step();
    check("t6_valid", out_valid, 1);
    check("t6_data",  out_data,  3'b111);
    check("t6_par",   par_err,   0);
    check("t6_frm",   frm_err,   0);
    step();

    // 7: accept and load on the same edge -> no overrun, no gap
    out_ready = 1'b0;
    drive_until(3'b100, 1'b0, 1'b1);
    step();
    check("t7_first_data", out_data, 3'b100);
    send(1'b1, 1);
    drive_until(3'b010, 1'b0, 1'b1);
    check("t7_held", out_data, 3'b100);
    out_ready = 1'b1;
    step();
    check("t7_valid", out_valid, 1);
    check("t7_data",  out_data,  3'b010);
    check("t7_ovr",   ovr,       0);
    step();
    check("t7_drained", out_valid, 0);

`ifdef PARITY_RX_STATS_EN
    // Saturation: 260 parity-error frames on top of 0 -> sticks at 255
    for (int i = 0; i < 260; i++) begin
      drive_until(3'b000, 1'b0, 1'b1);
      repeat (2) step();
    end
    check("sat_errcnt", err_cnt, 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
